fpga_pll_seq_ctrl: RTL and testbench

//  Power-up and lock-recovery sequencer for the FPGA PLLs (system 25MHz, audio 12.288MHz).

---
 rtl/fpga_pll_seq_pkg.sv | 20 ++
 rtl/fpga_sync2.sv | 35 +++
 rtl/fpga_pll_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fpga_pll_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pll_seq_pkg.sv
// rtl/fpga_pll_seq_pkg.sv - state codes and sizing helper for the PLL power-up sequencer
package fpga_pll_seq_pkg;

    // Codes 5-7 are unused; the FSM treats them as a fault and restarts from ST_PLL_RST.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    // Largest of three phase lengths; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fpga_sync2.sv
// rtl/fpga_sync2.sv - two-flop synchroniser for asynchronous level inputs
module fpga_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages clear on reset so the FSM sees "unlocked" until real samples arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fpga_pll_seq_ctrl.sv
// rtl/fpga_pll_seq_ctrl.sv - PLL reset/lock sequencer driving the system reset
module fpga_pll_seq_ctrl
    import fpga_pll_seq_pkg::*;
#(
    parameter int NUM_PLL       = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 4
) (
    input  logic               fclk,
    input  logic               reset,
    input  logic [NUM_PLL-1:0] pll_locked,
    input  logic               sw_restart,
    output logic [NUM_PLL-1:0] pll_areset,
    output logic               sys_reset_n,
    output logic               pll_fail,
    output logic [2:0]         seq_state,
    output logic [7:0]         lock_loss_cnt
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    logic [NUM_PLL-1:0] locked_s;
    logic               all_lk;

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RTY_W-1:0]   retry_cnt_q;
    logic [RTY_W-1:0]   retry_cnt_d;
    logic [RTY_W-1:0]   retry_inc;
    logic [7:0]         lock_loss_cnt_q;
    logic [7:0]         lock_loss_cnt_d;

    logic [NUM_PLL-1:0] pll_areset_q;
    logic [NUM_PLL-1:0] pll_areset_d;
    logic               sys_reset_n_q;
    logic               sys_reset_n_d;
    logic               pll_fail_q;
    logic               pll_fail_d;

    // Lock flags come from the PLL clock domains and must be resynchronised to fclk.
    fpga_sync2 #(
        .WIDTH (NUM_PLL)
    ) u_lock_sync (
        .clk (fclk),
        .rst (reset),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign all_lk    = &locked_s;
    assign retry_inc = retry_cnt_q + RTY_W'(1);

    // Sequencing rules; a software restart overrides whatever the FSM would have done.
    always_comb begin
        state_d         = state_q;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle still counts as a lock.
                if (all_lk) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == RTY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!all_lk) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d     = ST_RUN;
                    retry_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (!all_lk) begin
                    state_d = ST_PLL_RST;
                    if (lock_loss_cnt_q != 8'hFF) begin
                        lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (sw_restart) begin
            state_d         = ST_PLL_RST;
            retry_cnt_d     = '0;
            lock_loss_cnt_d = lock_loss_cnt_q;
        end
    end

    // Shared phase timer: zero on entry to any state, frozen in RUN and FAIL where it is unused.
    always_comb begin
        cnt_d = cnt_q;
        if (sw_restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_PLL_RST) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        pll_areset_d  = {NUM_PLL{(state_d == ST_PLL_RST) || (state_d == ST_FAIL)}};
        sys_reset_n_d = (state_d == ST_RUN);
        pll_fail_d    = (state_d == ST_FAIL);
    end

    // State, counters and output registers; reset holds the PLLs and system in reset.
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            retry_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
            pll_areset_q    <= '1;
            sys_reset_n_q   <= 1'b0;
            pll_fail_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
            pll_areset_q    <= pll_areset_d;
            sys_reset_n_q   <= sys_reset_n_d;
            pll_fail_q      <= pll_fail_d;
        end
    end

    assign pll_areset    = pll_areset_q;
    assign sys_reset_n   = sys_reset_n_q;
    assign pll_fail      = pll_fail_q;
    assign seq_state     = state_q;
    assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_fpga_pll_seq_ctrl.sv
// tb/tb_fpga_pll_seq_ctrl.sv - randomized self-checking bench for the PLL sequencer
module tb_fpga_pll_seq_ctrl;

    localparam int NP = 2;
    localparam int RC = 4;
    localparam int LT = 100;
    localparam int SC = 16;
    localparam int MR = 3;

    logic          fclk = 1'b0;
    logic          reset;
    logic [NP-1:0] pll_locked;
    logic          sw_restart;
    logic [NP-1:0] pll_areset;
    logic          sys_reset_n;
    logic          pll_fail;
    logic [2:0]    seq_state;
    logic [7:0]    lock_loss_cnt;

    always #5 fclk = ~fclk;

    fpga_pll_seq_ctrl #(
        .NUM_PLL       (NP),
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .fclk          (fclk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .sw_restart    (sw_restart),
        .pll_areset    (pll_areset),
        .sys_reset_n   (sys_reset_n),
        .pll_fail      (pll_fail),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: phase 0 reset pulse, 1 wait lock, 2 stable, 3 run, 4 fail.
    int          m_phase;
    int          m_age;
    int          m_tries;
    int          m_losses;
    logic [1:0]  hist[$];

    task automatic model_reset();
        m_phase  = 0;
        m_age    = 0;
        m_tries  = 0;
        m_losses = 0;
        hist.delete();
    endtask

    // Advance the reference by one clock edge given the inputs present before it.
    task automatic model_edge(input logic [1:0] raw, input logic rs);
        int         nxt;
        logic [1:0] seen;
        bit         ok;
        nxt  = m_phase;
        seen = (hist.size() == 2) ? hist[0] : 2'b00;
        ok   = (seen == 2'b11);
        if (rs) begin
            nxt     = 0;
            m_tries = 0;
        end else begin
            case (m_phase)
                0: if (m_age == RC - 1) nxt = 1;
                1: begin
                    if (ok) nxt = 2;
                    else if (m_age == LT - 1) begin
                        m_tries++;
                        nxt = (m_tries == MR) ? 4 : 0;
                    end
                end
                2: begin
                    if (!ok) nxt = 1;
                    else if (m_age == SC - 1) begin
                        nxt     = 3;
                        m_tries = 0;
                    end
                end
                3: begin
                    if (!ok) begin
                        nxt = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
        if (rs || nxt != m_phase) m_age = 0;
        else m_age++;
        m_phase = nxt;
        hist.push_back(raw);
        if (hist.size() > 2) void'(hist.pop_front());
    endtask

    task automatic compare_all();
        check_val("pll_areset", pll_areset, (m_phase == 0 || m_phase == 4) ? 2'b11 : 2'b00);
        check_val("sys_reset_n", sys_reset_n, m_phase == 3);
        check_val("pll_fail", pll_fail, m_phase == 4);
        check_val("seq_state", seq_state, m_phase);
        check_val("lock_loss_cnt", lock_loss_cnt, m_losses);
    endtask

    // Drive one cycle's inputs just after a falling edge, then sample at the next falling edge.
    task automatic cycle(input logic [1:0] lk, input logic rs);
        pll_locked = lk;
        sw_restart = rs;
        model_edge(lk, rs);
        @(negedge fclk);
        compare_all();
    endtask

    task automatic run_until(input int ph, input logic [1:0] lk, input int budget, input string tag);
        int k;
        k = 0;
        while (m_phase != ph && k < budget) begin
            cycle(lk, 1'b0);
            k++;
        end
        check_val(tag, seq_state, ph);
    endtask

    // Asynchronous reset pulse, asserted mid-cycle and released at a falling edge.
    task automatic pulse_reset();
        sw_restart = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge fclk);
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        int         areset_len;
        int         rise_at;
        int         drop_at;
        int         fail_at;
        int         lat;
        int         k;
        int         hold;
        logic [1:0] lk_r;
        logic       rs;

        reset      = 1'b1;
        pll_locked = 2'b00;
        sw_restart = 1'b0;
        model_reset();
        repeat (2) @(negedge fclk);
        check_val("rst_areset", pll_areset, 2'b11);
        check_val("rst_sys_reset_n", sys_reset_n, 0);
        check_val("rst_pll_fail", pll_fail, 0);
        check_val("rst_seq_state", seq_state, 0);
        check_val("rst_lock_loss", lock_loss_cnt, 0);
        reset = 1'b0;

        // Power-up with lock arriving at cycle 10.
        areset_len = (pll_areset == 2'b11) ? 1 : 0;
        rise_at    = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle((i >= 10) ? 2'b11 : 2'b00, 1'b0);
            if (pll_areset == 2'b11) areset_len++;
            if (sys_reset_n && rise_at < 0) rise_at = i;
        end
        check_val("areset_len", areset_len, RC);
        check_val("run_latency", rise_at - 10, 18);

        // Lock loss in RUN.
        drop_at = -1;
        for (int i = 0; i < 8; i++) begin
            cycle(2'b10, 1'b0);
            if (!sys_reset_n && drop_at < 0) drop_at = i;
        end
        check_val("loss_sysn_edge", drop_at, 2);
        check_val("loss_cnt_one", lock_loss_cnt, 1);
        run_until(3, 2'b11, 60, "relock_run");

        // Permanent lock failure.
        pulse_reset();
        fail_at = -1;
        for (int i = 1; i <= 3 * (RC + LT) + 10; i++) begin
            cycle(2'b01, 1'b0);
            if (pll_fail && fail_at < 0) fail_at = i;
        end
        check_val("fail_entry_cycle", fail_at, 3 * (RC + LT));
        check_val("fail_flag", pll_fail, 1);
        check_val("fail_state", seq_state, 4);
        check_val("fail_sysn", sys_reset_n, 0);

        // Software restart out of FAIL.
        cycle(2'b11, 1'b1);
        check_val("swr_fail_flag", pll_fail, 0);
        check_val("swr_fail_state", seq_state, 0);

        // Glitch during STABLE forces a fresh stability window.
        run_until(2, 2'b11, 40, "reach_stable");
        k = 0;
        while (m_age < 10 && k < 40) begin
            cycle(2'b11, 1'b0);
            k++;
        end
        cycle(2'b01, 1'b0);
        lat = 0;
        while (!sys_reset_n && lat < 60) begin
            cycle(2'b11, 1'b0);
            lat++;
        end
        check_val("stable_restart_lat", lat, 19);

        // Software restart out of RUN.
        cycle(2'b11, 1'b1);
        check_val("swr_run_state", seq_state, 0);
        check_val("swr_run_sysn", sys_reset_n, 0);
        run_until(3, 2'b11, 60, "swr_relock");

        // Saturate the lock loss counter.
        for (int n = 0; n < 256; n++) begin
            cycle(2'b00, 1'b0);
            cycle(2'b11, 1'b0);
            cycle(2'b11, 1'b0);
            run_until(3, 2'b11, 80, "loss_relock");
        end
        check_val("loss_saturate", lock_loss_cnt, 255);

        // Asynchronous reset in the middle of WAIT_LOCK.
        pulse_reset();
        for (int i = 0; i < RC + 50; i++) cycle(2'b00, 1'b0);
        check_val("mid_wait_state", seq_state, 1);
        pulse_reset();
        check_val("mid_rst_areset", pll_areset, 2'b11);
        check_val("mid_rst_state", seq_state, 0);
        run_until(3, 2'b11, 60, "after_reset_run");

        // Random lock behaviour, restarts and resets.
        hold = 0;
        lk_r = 2'b11;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                lk_r = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                hold = $urandom_range(1, 40);
            end
            hold--;
            rs = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else cycle(lk_r, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
